aes_axil_regbank: RTL and testbench

//  Parametrised AXI4-Lite slave register bank fronting the AES core; successor to the fixed 4-register slave.

---
 rtl/aes_axil_regbank.sv | 204 ++++++++++++++++++++
 tb/tb_aes_axil_regbank.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_axil_regbank.sv
// AXI4-Lite slave register bank in front of the AES core: CTRL, STATUS,
// NUM_RW key/data registers and NUM_RO read-only result registers.
module aes_axil_regbank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_RW     = 8,
    parameter int NUM_RO     = 4
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic                         S_AXI_AWVALID,
    output logic                         S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                         S_AXI_WVALID,
    output logic                         S_AXI_WREADY,
    output logic [1:0]                   S_AXI_BRESP,
    output logic                         S_AXI_BVALID,
    input  logic                         S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic                         S_AXI_ARVALID,
    output logic                         S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                   S_AXI_RRESP,
    output logic                         S_AXI_RVALID,
    input  logic                         S_AXI_RREADY,
    input  logic                         core_busy,
    input  logic                         core_done,
    input  logic [NUM_RO*DATA_WIDTH-1:0] ro_in,
    output logic [NUM_RW*DATA_WIDTH-1:0] rw_out,
    output logic                         start_pulse,
    output logic                         irq
);
    localparam int NUM_REGS = NUM_RW + NUM_RO + 2;
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam logic [IDX_W:0] REGS_LIM = (IDX_W+1)'(NUM_REGS);
    localparam logic [IDX_W:0] RO_BASE  = (IDX_W+1)'(NUM_RW + 2);

    typedef enum logic {W_ACCEPT, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_state_next;
    r_state_t r_state, r_state_next;

    logic                  ready_en;
    logic                  aw_held, w_held;
    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rw_q [NUM_RW];
    logic                  irq_en, done_q, err_q;

    logic                  aw_fire, w_fire, ar_fire, commit, wr_err, ctrl_wr, stat_wr;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] wr_data, rd_data;
    logic [STRB_W-1:0]     wr_strb;
    logic                  rd_err;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR};

    assign aw_fire = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_fire  = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_fire = S_AXI_ARVALID & S_AXI_ARREADY;

    // A beat latched earlier takes precedence over the live bus for the commit.
    assign wr_idx  = aw_held ? aw_idx_q : S_AXI_AWADDR[ADDR_LSB +: IDX_W];
    assign wr_data = w_held ? wdata_q : S_AXI_WDATA;
    assign wr_strb = w_held ? wstrb_q : S_AXI_WSTRB;
    assign commit  = (w_state == W_ACCEPT) && (aw_held || aw_fire) && (w_held || w_fire);
    assign wr_err  = {1'b0, wr_idx} >= RO_BASE;
    assign ctrl_wr = commit && !wr_err && (wr_idx == '0) && wr_strb[0];
    assign stat_wr = commit && !wr_err && (wr_idx == IDX_W'(1)) && wr_strb[0];
    assign rd_idx  = S_AXI_ARADDR[ADDR_LSB +: IDX_W];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state <= W_ACCEPT;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_next;
            r_state <= r_state_next;
        end
    end

    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_ACCEPT: if (commit) w_state_next = W_RESP;
            W_RESP:   if (S_AXI_BREADY) w_state_next = W_ACCEPT;
            default:  w_state_next = W_ACCEPT;
        endcase
    end

    always_comb begin
        S_AXI_AWREADY = ready_en && (w_state == W_ACCEPT) && !aw_held;
        S_AXI_WREADY  = ready_en && (w_state == W_ACCEPT) && !w_held;
        S_AXI_BVALID  = (w_state == W_RESP);
        S_AXI_BRESP   = bresp_q;
    end

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_fire) r_state_next = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_ARREADY = ready_en && (r_state == R_IDLE);
        S_AXI_RVALID  = (r_state == R_DATA);
        S_AXI_RDATA   = rdata_q;
        S_AXI_RRESP   = rresp_q;
    end

    // Readies stay low while in reset and come up on the first clock after release.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ready_en <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= 2'b00;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
        end else begin
            ready_en <= 1'b1;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp_q <= wr_err ? 2'b10 : 2'b00;
            end else begin
                if (aw_fire) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= S_AXI_AWADDR[ADDR_LSB +: IDX_W];
                end
                if (w_fire) begin
                    w_held  <= 1'b1;
                    wdata_q <= S_AXI_WDATA;
                    wstrb_q <= S_AXI_WSTRB;
                end
            end
            if (ar_fire) begin
                rdata_q <= rd_data;
                rresp_q <= rd_err ? 2'b10 : 2'b00;
            end
        end
    end

    // DONE set beats a simultaneous write-1-to-clear.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int k = 0; k < NUM_RW; k++) rw_q[k] <= '0;
            irq_en      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            start_pulse <= 1'b0;
            irq         <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_RW; k++) begin
                if (commit && (wr_idx == IDX_W'(k + 2))) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wr_strb[b]) rw_q[k][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
            if (ctrl_wr) irq_en <= wr_data[1];
            start_pulse <= ctrl_wr && wr_data[0] && !core_busy;
            if (ctrl_wr && wr_data[0] && core_busy) err_q <= 1'b1;
            else if (stat_wr && wr_data[2])         err_q <= 1'b0;
            if (core_done)                          done_q <= 1'b1;
            else if (stat_wr && wr_data[1])         done_q <= 1'b0;
            irq <= irq_en & done_q;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if ({1'b0, rd_idx} >= REGS_LIM) rd_err = 1'b1;
        else if (rd_idx == '0)          rd_data[1] = irq_en;
        else if (rd_idx == IDX_W'(1))   rd_data[2:0] = {err_q, done_q, core_busy};
        for (int k = 0; k < NUM_RW; k++) begin
            if (rd_idx == IDX_W'(k + 2)) rd_data = rw_q[k];
        end
        for (int k = 0; k < NUM_RO; k++) begin
            if (rd_idx == IDX_W'(NUM_RW + 2 + k)) rd_data = ro_in[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        rw_out = '0;
        for (int k = 0; k < NUM_RW; k++) rw_out[k*DATA_WIDTH +: DATA_WIDTH] = rw_q[k];
    end
endmodule

// File: tb/tb_aes_axil_regbank.sv
// Directed bench for aes_axil_regbank: AXI-Lite writes/reads checked against a
// register-level model, with a per-cycle monitor on rw_out, start_pulse and irq.
module tb_aes_axil_regbank;
    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int NRW   = 8;
    localparam int NRO   = 4;
    localparam int NREGS = NRW + NRO + 2;
    localparam int SW    = DW / 8;

    logic              ACLK = 1'b0;
    logic              ARESETN = 1'b0;
    logic [AW-1:0]     S_AXI_AWADDR = '0;
    logic              S_AXI_AWVALID = 1'b0;
    logic              S_AXI_AWREADY;
    logic [DW-1:0]     S_AXI_WDATA = '0;
    logic [SW-1:0]     S_AXI_WSTRB = '0;
    logic              S_AXI_WVALID = 1'b0;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY = 1'b0;
    logic [AW-1:0]     S_AXI_ARADDR = '0;
    logic              S_AXI_ARVALID = 1'b0;
    logic              S_AXI_ARREADY;
    logic [DW-1:0]     S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY = 1'b0;
    logic              core_busy = 1'b0;
    logic              core_done = 1'b0;
    logic [NRO*DW-1:0] ro_in;
    logic [NRW*DW-1:0] rw_out;
    logic              start_pulse;
    logic              irq;

    int vectors = 0;
    int miscompares = 0;
    int pulse_count = 0;

    logic [DW-1:0] m_rw [NRW];
    logic m_irq_en = 1'b0, m_done = 1'b0, m_err = 1'b0;
    logic exp_start = 1'b0, irq_pipe = 1'b0;

    aes_axil_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RW(NRW), .NUM_RO(NRO)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .core_busy(core_busy), .core_done(core_done), .ro_in(ro_in), .rw_out(rw_out),
        .start_pulse(start_pulse), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        for (int k = 0; k < NRO; k++) ro_in[k*DW +: DW] = 32'hC0DE_0000 + 32'(k);
        for (int k = 0; k < NRW; k++) m_rw[k] = '0;
    end

    always @(posedge ACLK) if (start_pulse) pulse_count++;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < NRW; k++) m_rw[k] = '0;
        m_irq_en = 1'b0; m_done = 1'b0; m_err = 1'b0;
        exp_start = 1'b0; irq_pipe = 1'b0;
    endtask

    // Register-level effect of one committed write, evaluated with the inputs seen at commit.
    task automatic modelWrite(input int idx, input logic [DW-1:0] data, input logic [SW-1:0] strb,
                              output logic [1:0] resp);
        resp = 2'b00;
        if (idx >= NRW + 2) begin
            resp = 2'b10;
        end else if (idx == 0) begin
            if (strb[0]) begin
                m_irq_en = data[1];
                if (data[0]) begin
                    if (core_busy) m_err = 1'b1;
                    else           exp_start = 1'b1;
                end
            end
        end else if (idx == 1) begin
            if (strb[0]) begin
                if (data[1] && !core_done) m_done = 1'b0;
                if (data[2])               m_err = 1'b0;
            end
        end else begin
            for (int b = 0; b < SW; b++) if (strb[b]) m_rw[idx-2][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic modelRead(input int idx, output logic [DW-1:0] data, output logic [1:0] resp);
        data = '0;
        resp = 2'b00;
        if (idx >= NREGS)       resp = 2'b10;
        else if (idx == 0)      data[1] = m_irq_en;
        else if (idx == 1)      data[2:0] = {m_err, m_done, core_busy};
        else if (idx < NRW + 2) data = m_rw[idx-2];
        else                    data = 32'hC0DE_0000 + 32'(idx - NRW - 2);
    endtask

    // One AXI write; W may lead AW by w_lead cycles and BREADY is withheld for bready_delay cycles.
    task automatic applyStimulus(input int idx, input logic [DW-1:0] data, input logic [SW-1:0] strb,
                                 input int w_lead, input int bready_delay, output logic [1:0] resp);
        bit aw_done = 1'b0, w_done = 1'b0, aw_go, w_go;
        int cyc = 0;
        logic [1:0] exp_resp;
        while (!(aw_done && w_done) && cyc < 40) begin
            @(negedge ACLK);
            if (w_done && !aw_done) checkOutput("wready_after_w", 64'(S_AXI_WREADY), 64'(0));
            S_AXI_AWADDR  = AW'(idx * SW);
            S_AXI_WDATA   = data;
            S_AXI_WSTRB   = strb;
            S_AXI_WVALID  = !w_done;
            S_AXI_AWVALID = !aw_done && (cyc >= w_lead);
            aw_go = S_AXI_AWVALID && S_AXI_AWREADY;
            w_go  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge ACLK);
            #1;
            aw_done = aw_done | aw_go;
            w_done  = w_done | w_go;
            S_AXI_AWVALID = 1'b0;
            S_AXI_WVALID  = 1'b0;
            cyc++;
        end
        checkOutput("write_handshake", 64'({aw_done, w_done}), 64'(2'b11));
        modelWrite(idx, data, strb, exp_resp);
        for (int k = 0; k < bready_delay; k++) begin
            @(negedge ACLK);
            checkOutput("bvalid_hold", 64'(S_AXI_BVALID), 64'(1));
            checkOutput("bresp_hold", 64'(S_AXI_BRESP), 64'(exp_resp));
        end
        @(negedge ACLK);
        cyc = 0;
        while (!S_AXI_BVALID && cyc < 20) begin
            @(negedge ACLK);
            cyc++;
        end
        checkOutput("bvalid", 64'(S_AXI_BVALID), 64'(1));
        checkOutput("bresp", 64'(S_AXI_BRESP), 64'(exp_resp));
        resp = S_AXI_BRESP;
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK);
        #1;
        S_AXI_BREADY = 1'b0;
        checkOutput("bvalid_drop", 64'(S_AXI_BVALID), 64'(0));
    endtask

    task automatic readRegister(input int byte_addr, output logic [DW-1:0] data, output logic [1:0] resp);
        int cyc = 0;
        @(negedge ACLK);
        S_AXI_ARADDR  = AW'(byte_addr);
        S_AXI_ARVALID = 1'b1;
        while (!S_AXI_ARREADY && cyc < 20) begin
            @(negedge ACLK);
            cyc++;
        end
        checkOutput("arready", 64'(S_AXI_ARREADY), 64'(1));
        @(posedge ACLK);
        #1;
        S_AXI_ARVALID = 1'b0;
        @(negedge ACLK);
        cyc = 0;
        while (!S_AXI_RVALID && cyc < 20) begin
            @(negedge ACLK);
            cyc++;
        end
        checkOutput("rvalid", 64'(S_AXI_RVALID), 64'(1));
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK);
        #1;
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic verifyRead(input int idx, input int low_bits, output logic [DW-1:0] data,
                              output logic [1:0] resp);
        logic [DW-1:0] exp_data;
        logic [1:0] exp_resp;
        readRegister(idx * SW + low_bits, data, resp);
        modelRead(idx, exp_data, exp_resp);
        checkOutput($sformatf("rdata_idx%0d", idx), 64'(data), 64'(exp_data));
        checkOutput($sformatf("rresp_idx%0d", idx), 64'(resp), 64'(exp_resp));
    endtask

    task automatic pulseDone();
        @(negedge ACLK);
        core_done = 1'b1;
        @(posedge ACLK);
        #1;
        core_done = 1'b0;
        m_done = 1'b1;
    endtask

    // Per-cycle monitor: irq is the model's IRQ_EN & DONE delayed by one clock.
    always @(negedge ACLK) begin
        if (ARESETN) begin
            for (int k = 0; k < NRW; k++)
                checkOutput($sformatf("rw_out%0d", k), 64'(rw_out[k*DW +: DW]), 64'(m_rw[k]));
            checkOutput("start_pulse", 64'(start_pulse), 64'(exp_start));
            checkOutput("irq", 64'(irq), 64'(irq_pipe));
            exp_start = 1'b0;
            irq_pipe  = m_irq_en & m_done;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] rd;
        logic [1:0] rs, bs;

        #12;
        checkOutput("reset_awready", 64'(S_AXI_AWREADY), 64'(0));
        checkOutput("reset_wready", 64'(S_AXI_WREADY), 64'(0));
        checkOutput("reset_bvalid", 64'(S_AXI_BVALID), 64'(0));
        checkOutput("reset_arready", 64'(S_AXI_ARREADY), 64'(0));
        checkOutput("reset_rvalid", 64'(S_AXI_RVALID), 64'(0));
        checkOutput("reset_resp", 64'({S_AXI_BRESP, S_AXI_RRESP}), 64'(0));
        checkOutput("reset_rdata", 64'(S_AXI_RDATA), 64'(0));
        checkOutput("reset_start_irq", 64'({start_pulse, irq}), 64'(0));
        checkOutput("reset_rw_out", 64'(|rw_out), 64'(0));
        @(negedge ACLK);
        ARESETN = 1'b1;

        $display("[TB] test 1: RW registers write/read-back");
        for (int k = 0; k < NRW; k++) applyStimulus(2 + k, 32'h11 + 32'(k), 4'hF, 0, 0, bs);
        for (int k = 0; k < NRW; k++) begin
            verifyRead(2 + k, 0, rd, rs);
            checkOutput($sformatf("lit_rw%0d", k), 64'({rs, rd}), 64'({2'b00, 32'h11 + 32'(k)}));
            checkOutput($sformatf("lit_rw_out%0d", k), 64'(rw_out[k*DW +: DW]), 64'(32'h11 + 32'(k)));
        end

        $display("[TB] test 2: byte strobes");
        applyStimulus(2, 32'hAABBCCDD, 4'hF, 0, 0, bs);
        applyStimulus(2, 32'h00000011, 4'b0001, 0, 0, bs);
        verifyRead(2, 0, rd, rs);
        checkOutput("lit_strb0001", 64'(rd), 64'(32'hAABBCC11));
        applyStimulus(2, 32'h55667788, 4'b1010, 0, 0, bs);
        verifyRead(2, 3, rd, rs);
        checkOutput("lit_strb1010", 64'(rd), 64'(32'h55BB7711));

        $display("[TB] test 3: W before AW, delayed BREADY");
        applyStimulus(3, 32'hDEADBEEF, 4'hF, 3, 5, bs);
        checkOutput("lit_late_aw_bresp", 64'(bs), 64'(2'b00));
        verifyRead(3, 0, rd, rs);
        checkOutput("lit_late_aw", 64'(rd), 64'(32'hDEADBEEF));

        $display("[TB] test 4: SLVERR decode");
        verifyRead(NREGS, 0, rd, rs);
        checkOutput("lit_oor_read", 64'({rs, rd}), 64'({2'b10, 32'h0}));
        verifyRead(NREGS + 1, 1, rd, rs);
        applyStimulus(NRW + 2, 32'h12345678, 4'hF, 0, 0, bs);
        checkOutput("lit_ro_write", 64'(bs), 64'(2'b10));
        applyStimulus(NREGS + 1, 32'hFFFFFFFF, 4'hF, 1, 2, bs);
        checkOutput("lit_oor_write", 64'(bs), 64'(2'b10));
        verifyRead(NRW + 2, 0, rd, rs);
        checkOutput("lit_ro_value", 64'({rs, rd}), 64'({2'b00, 32'hC0DE0000}));
        verifyRead(NRW + 5, 0, rd, rs);

        $display("[TB] test 5: START, DONE and irq");
        applyStimulus(0, 32'h3, 4'hF, 0, 0, bs);
        checkOutput("lit_pulse_count1", 64'(pulse_count), 64'(1));
        verifyRead(0, 0, rd, rs);
        checkOutput("lit_ctrl", 64'(rd), 64'(32'h2));
        pulseDone();
        repeat (2) @(negedge ACLK);
        checkOutput("lit_irq_set", 64'(irq), 64'(1));
        verifyRead(1, 0, rd, rs);
        checkOutput("lit_status_done", 64'(rd), 64'(32'h2));
        @(negedge ACLK);
        core_done = 1'b1;
        applyStimulus(1, 32'h2, 4'hF, 0, 0, bs);
        core_done = 1'b0;
        verifyRead(1, 0, rd, rs);
        checkOutput("lit_done_set_wins", 64'(rd), 64'(32'h2));
        applyStimulus(1, 32'h2, 4'hF, 0, 0, bs);
        repeat (2) @(negedge ACLK);
        checkOutput("lit_irq_clear", 64'(irq), 64'(0));
        verifyRead(1, 0, rd, rs);
        checkOutput("lit_status_clear", 64'(rd), 64'(32'h0));

        $display("[TB] test 6: START while busy, reset mid-read");
        core_busy = 1'b1;
        applyStimulus(0, 32'h1, 4'hF, 0, 0, bs);
        verifyRead(1, 0, rd, rs);
        checkOutput("lit_status_err", 64'(rd), 64'(32'h5));
        core_busy = 1'b0;
        applyStimulus(0, 32'h1, 4'b0000, 0, 0, bs);
        checkOutput("lit_pulse_count2", 64'(pulse_count), 64'(1));
        applyStimulus(1, 32'h4, 4'hF, 0, 0, bs);
        verifyRead(1, 0, rd, rs);
        checkOutput("lit_err_clear", 64'(rd), 64'(32'h0));

        @(negedge ACLK);
        checkOutput("arready_pre_reset", 64'(S_AXI_ARREADY), 64'(1));
        S_AXI_ARADDR  = AW'(2 * SW);
        S_AXI_ARVALID = 1'b1;
        @(posedge ACLK);
        #1;
        S_AXI_ARVALID = 1'b0;
        @(negedge ACLK);
        checkOutput("rvalid_pre_reset", 64'(S_AXI_RVALID), 64'(1));
        #2;
        ARESETN = 1'b0;
        modelReset();
        #1;
        checkOutput("rvalid_in_reset", 64'(S_AXI_RVALID), 64'(0));
        checkOutput("readies_in_reset", 64'({S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY}), 64'(0));
        checkOutput("rw_out_in_reset", 64'(rw_out[0 +: DW]), 64'(0));
        @(posedge ACLK);
        #3;
        ARESETN = 1'b1;
        verifyRead(2, 0, rd, rs);
        checkOutput("lit_after_reset", 64'(rd), 64'(0));
        applyStimulus(9, 32'hCAFEF00D, 4'hF, 0, 1, bs);
        verifyRead(9, 0, rd, rs);

        repeat (3) @(negedge ACLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
